// File: rtl/fc_mac_sequencer.sv
// fc_mac_sequencer
//   Time-multiplexed controller for the fully connected layer. Collects INPUT_NUM
//   features as BEATS beats of LANES lanes, then runs one shared MAC over INPUT_NUM
//   products per class, adds the class bias and streams OUTPUT_NUM scores out.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   i_in_valid / o_in_ready    feature beat handshake (ready only while loading)
//   i_in_data_1..3             signed features, lanes 0..2
//   o_weight_addr / i_weight_data   weight ROM, data valid one cycle after address
//   o_bias_addr / i_bias_data       bias ROM, data valid one cycle after address
//   o_out_valid / i_out_ready  score handshake
//   o_out_data, o_out_idx      signed score and its class index
//   o_busy                     high while computing or presenting scores
//   o_done                     one-cycle pulse after the last score is accepted
module fc_mac_sequencer #(
  parameter int unsigned INPUT_NUM  = 48,
  parameter int unsigned OUTPUT_NUM = 10,
  parameter int unsigned LANES      = 3,
  parameter int unsigned BEATS      = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned IN_BITS    = 12,
  parameter int unsigned ACC_BITS   = 24,
  parameter int unsigned OUT_SHIFT  = 7,
  parameter int unsigned OUT_BITS   = 12,
  parameter int unsigned WADDR_BITS = $clog2(INPUT_NUM * OUTPUT_NUM),
  parameter int unsigned CLASS_BITS = $clog2(OUTPUT_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic signed [IN_BITS-1:0]    i_in_data_1,
  input  logic signed [IN_BITS-1:0]    i_in_data_2,
  input  logic signed [IN_BITS-1:0]    i_in_data_3,
  output logic [WADDR_BITS-1:0]        o_weight_addr,
  input  logic signed [DATA_BITS-1:0]  i_weight_data,
  output logic [CLASS_BITS-1:0]        o_bias_addr,
  input  logic signed [DATA_BITS-1:0]  i_bias_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [OUT_BITS-1:0]          o_out_data,
  output logic [CLASS_BITS-1:0]        o_out_idx,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned IDX_BITS  = $clog2(INPUT_NUM);
  localparam int unsigned BEAT_BITS = $clog2(BEATS);
  localparam int unsigned PROD_BITS = DATA_BITS + IN_BITS;

  typedef enum logic [1:0] {StLoad, StCompute, StDrain, StOut} state_t;

  state_t                      r_state, w_state_next;
  logic [BEAT_BITS-1:0]        r_beat;
  logic [IDX_BITS-1:0]         r_idx;
  logic [CLASS_BITS-1:0]       r_class;
  logic signed [ACC_BITS-1:0]  r_acc;
  logic [OUT_BITS-1:0]         r_out_data;
  logic                        r_done;
  logic signed [IN_BITS-1:0]   r_feat [INPUT_NUM];
  logic signed [IN_BITS-1:0]   r_feat_d;

  logic signed [IN_BITS-1:0]   w_lane [LANES];
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic                        w_last_beat;
  logic                        w_last_idx;
  logic                        w_last_class;
  logic signed [PROD_BITS-1:0] w_prod;
  logic signed [ACC_BITS-1:0]  w_prod_ext;
  logic signed [ACC_BITS-1:0]  w_bias_ext;
  logic signed [ACC_BITS-1:0]  w_acc_mac;
  logic signed [ACC_BITS-1:0]  w_acc_fin;

  assign w_lane[0] = i_in_data_1;
  assign w_lane[1] = i_in_data_2;
  assign w_lane[2] = i_in_data_3;

  assign w_in_fire    = i_in_valid && (r_state == StLoad);
  assign w_out_fire   = i_out_ready && (r_state == StOut);
  assign w_last_beat  = (r_beat == BEAT_BITS'(BEATS - 1));
  assign w_last_idx   = (r_idx == IDX_BITS'(INPUT_NUM - 1));
  assign w_last_class = (r_class == CLASS_BITS'(OUTPUT_NUM - 1));

  // r_feat_d is the feature addressed one cycle ago, lining it up with the ROM latency.
  assign w_prod     = i_weight_data * r_feat_d;
  assign w_prod_ext = {{(ACC_BITS - PROD_BITS){w_prod[PROD_BITS-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_BITS - DATA_BITS){i_bias_data[DATA_BITS-1]}}, i_bias_data};
  assign w_acc_mac  = r_acc + w_prod_ext;
  assign w_acc_fin  = w_acc_mac + w_bias_ext;

  // Address held at the last issued value through DRAIN/OUT.
  assign o_weight_addr = WADDR_BITS'(r_class) * WADDR_BITS'(INPUT_NUM) + WADDR_BITS'(r_idx);
  assign o_bias_addr   = r_class;
  assign o_in_ready    = (r_state == StLoad);
  assign o_busy        = (r_state != StLoad);
  assign o_out_valid   = (r_state == StOut);
  assign o_out_data    = r_out_data;
  assign o_out_idx     = r_class;
  assign o_done        = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StLoad:    if (w_in_fire && w_last_beat) w_state_next = StCompute;
      StCompute: if (w_last_idx) w_state_next = StDrain;
      StDrain:   w_state_next = StOut;
      StOut:     if (w_out_fire) w_state_next = w_last_class ? StLoad : StCompute;
      default:   w_state_next = StLoad;
    endcase
  end

  // Feature buffer needs no reset: a fresh image always overwrites all entries.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      for (int k = 0; k < LANES; k++) begin
        r_feat[IDX_BITS'(k * BEATS) + IDX_BITS'(r_beat)] <= w_lane[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat     <= '0;
      r_idx      <= '0;
      r_class    <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_done     <= 1'b0;
      r_feat_d   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_feat_d <= r_feat[r_idx];
      case (r_state)
        StLoad: begin
          if (w_in_fire) begin
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            if (w_last_beat) begin
              r_idx   <= '0;
              r_class <= '0;
              r_acc   <= '0;
            end
          end
        end
        StCompute: begin
          // Cycle 0 only issues the first address; no product is available yet.
          if (r_idx != '0) r_acc <= w_acc_mac;
          if (!w_last_idx) r_idx <= r_idx + 1'b1;
        end
        StDrain: begin
          r_acc      <= w_acc_fin;
          r_out_data <= w_acc_fin[OUT_SHIFT+OUT_BITS-1:OUT_SHIFT];
        end
        StOut: begin
          if (w_out_fire) begin
            r_idx <= '0;
            r_acc <= '0;
            if (w_last_class) begin
              r_class <= '0;
              r_done  <= 1'b1;
            end else begin
              r_class <= r_class + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// tb_fc_mac_sequencer
//   Randomised self-checking bench. Weight and bias ROMs are modelled as one-cycle
//   synchronous memories; expected scores come from a plain dot-product model.
module tb_fc_mac_sequencer;

  localparam int INPUT_NUM  = 48;
  localparam int OUTPUT_NUM = 10;
  localparam int BEATS      = 16;

  logic              clk;
  logic              rst_n;
  logic              i_in_valid;
  logic              o_in_ready;
  logic signed [11:0] i_in_data_1;
  logic signed [11:0] i_in_data_2;
  logic signed [11:0] i_in_data_3;
  logic [8:0]        o_weight_addr;
  logic signed [7:0] i_weight_data;
  logic [3:0]        o_bias_addr;
  logic signed [7:0] i_bias_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [11:0]       o_out_data;
  logic [3:0]        o_out_idx;
  logic              o_busy;
  logic              o_done;

  logic signed [11:0] feat [INPUT_NUM];
  logic signed [7:0]  wrom [512];
  logic signed [7:0]  brom [16];
  logic [11:0]        exp_s [OUTPUT_NUM];

  int errors = 0;
  int checks = 0;

  fc_mac_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_data_1   (i_in_data_1),
    .i_in_data_2   (i_in_data_2),
    .i_in_data_3   (i_in_data_3),
    .o_weight_addr (o_weight_addr),
    .i_weight_data (i_weight_data),
    .o_bias_addr   (o_bias_addr),
    .i_bias_data   (i_bias_data),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .o_out_idx     (o_out_idx),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    i_weight_data <= wrom[o_weight_addr];
    i_bias_data   <= brom[o_bias_addr];
  end

  // score[c] = (sum_i w[c*48+i]*f[i] + b[c]) >>> 7, low 12 bits
  function automatic void build_expected();
    for (int c = 0; c < OUTPUT_NUM; c++) begin
      int s;
      s = 0;
      for (int i = 0; i < INPUT_NUM; i++) s += int'(wrom[c*INPUT_NUM+i]) * int'(feat[i]);
      s += int'(brom[c]);
      s = s >>> 7;
      exp_s[c] = s[11:0];
    end
  endfunction

  task automatic fill(input int mode);
    // mode 0: all +1, bias 0; 1: all -1, bias 5; 2: class stride; 3: random
    for (int i = 0; i < INPUT_NUM; i++) feat[i] = (mode == 3) ? 12'($urandom) : 12'sd128;
    for (int a = 0; a < 512; a++) begin
      case (mode)
        0:       wrom[a] = 8'sd1;
        1:       wrom[a] = -8'sd1;
        2:       wrom[a] = 8'(a / INPUT_NUM + 1);
        default: wrom[a] = 8'($urandom);
      endcase
    end
    for (int c = 0; c < 16; c++) begin
      case (mode)
        1:       brom[c] = 8'sd5;
        3:       brom[c] = 8'($urandom);
        default: brom[c] = 8'sd0;
      endcase
    end
    build_expected();
  endtask

  task automatic load_image();
    for (int b = 0; b < BEATS; b++) begin
      repeat ($urandom_range(2)) begin
        @(negedge clk);
        i_in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (o_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready beat=%0d got=%b want=1", b, o_in_ready);
      end
      i_in_valid  = 1'b1;
      i_in_data_1 = feat[b];
      i_in_data_2 = feat[BEATS + b];
      i_in_data_3 = feat[2*BEATS + b];
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_to_compute busy=%b in_ready=%b want busy=1 in_ready=0",
               o_busy, o_in_ready);
    end
  endtask

  task automatic collect_scores(input int ready_pct, input int stall_class, input bit noise);
    int got, guard, cyc, last_hs, stalls;
    bit rdy, gap_pending;
    got = 0; guard = 0; cyc = 0; last_hs = 0; stalls = 0; gap_pending = 1'b0;
    while (got < OUTPUT_NUM && guard < 3000) begin
      @(negedge clk);
      cyc++; guard++;
      i_in_valid = 1'b0;
      checks++;
      if (o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_while_busy got=%b want=0", o_in_ready);
      end
      if (o_out_valid === 1'b1) begin
        checks += 2;
        if (o_out_data !== exp_s[got]) begin
          errors++;
          $display("FAIL score class=%0d got=%h want=%h", got, o_out_data, exp_s[got]);
        end
        if (o_out_idx !== 4'(got)) begin
          errors++;
          $display("FAIL out_idx got=%0d want=%0d", o_out_idx, got);
        end
        if (gap_pending) begin
          gap_pending = 1'b0;
          checks++;
          if (cyc - last_hs != INPUT_NUM + 2) begin
            errors++;
            $display("FAIL class_latency got=%0d want=%0d", cyc - last_hs, INPUT_NUM + 2);
          end
        end
        if (got == stall_class && stalls < 5) begin
          rdy = 1'b0;
          stalls++;
          checks++;
          if (o_weight_addr !== 9'(got * INPUT_NUM + INPUT_NUM - 1)) begin
            errors++;
            $display("FAIL stall_addr got=%0d want=%0d", o_weight_addr,
                     got * INPUT_NUM + INPUT_NUM - 1);
          end
        end else begin
          rdy = (int'($urandom_range(99)) < ready_pct);
        end
        i_out_ready = rdy;
        if (rdy) begin
          got++;
          last_hs = cyc;
          gap_pending = 1'b1;
        end
      end else begin
        i_out_ready = 1'($urandom_range(1));
        if (noise) begin
          i_in_valid  = 1'($urandom_range(1));
          i_in_data_1 = 12'($urandom);
          i_in_data_2 = 12'($urandom);
          i_in_data_3 = 12'($urandom);
        end
      end
    end
    checks++;
    if (got < OUTPUT_NUM) begin
      errors++;
      $display("FAIL score_timeout got=%0d want=%0d", got, OUTPUT_NUM);
    end
    @(negedge clk);
    i_out_ready = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b in_ready=%b want 1 0 1", o_done, o_busy,
               o_in_ready);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got=%b want=0", o_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl in_ready=%b out_valid=%b done=%b busy=%b want 1 0 0 0",
               o_in_ready, o_out_valid, o_done, o_busy);
    end
    checks++;
    if (o_weight_addr !== 9'd0 || o_bias_addr !== 4'd0 || o_out_data !== 12'd0 ||
        o_out_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_data waddr=%0d baddr=%0d data=%h idx=%0d want all 0",
               o_weight_addr, o_bias_addr, o_out_data, o_out_idx);
    end
  endtask

  task automatic test_all_ones();
    fill(0);
    load_image();
    collect_scores(100, -1, 1'b0);
  endtask

  task automatic test_neg_bias();
    fill(1);
    load_image();
    collect_scores(100, -1, 1'b0);
  endtask

  task automatic test_stride();
    fill(2);
    load_image();
    collect_scores(70, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    fill(3);
    load_image();
    collect_scores(100, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      fill(3);
      load_image();
      collect_scores(50, -1, 1'b1);
    end
  endtask

  task automatic test_reset_mid_compute();
    int guard;
    fill(3);
    load_image();
    guard = 0;
    i_out_ready = 1'b1;
    while (!(o_out_idx == 4'd6 && o_busy && !o_out_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL reach_class6 got_idx=%0d want=6", o_out_idx);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_in_valid  = 1'b1;
      i_in_data_1 = 12'($urandom);
      checks++;
      if (o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_compute got=%b want=0", o_in_ready);
      end
    end
    @(negedge clk);
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_out_idx !== 4'd0 ||
        o_weight_addr !== 9'd0 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset in_ready=%b busy=%b idx=%0d waddr=%0d valid=%b want 1 0 0 0 0",
               o_in_ready, o_busy, o_out_idx, o_weight_addr, o_out_valid);
    end
    fill(3);
    load_image();
    collect_scores(80, -1, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data_1 = '0;
    i_in_data_2 = '0;
    i_in_data_3 = '0;
    i_out_ready = 1'b0;
    for (int a = 0; a < 512; a++) wrom[a] = '0;
    for (int c = 0; c < 16; c++) brom[c] = '0;
    test_reset();
    test_all_ones();
    test_neg_bias();
    test_stride();
    test_backpressure();
    test_random();
    test_reset_mid_compute();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
